// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG entropy post-processing stage.
package trng_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

    localparam int DATA_W_DEF     = 32;
    localparam int RCT_CUTOFF_DEF = 32;
    localparam int RCT_CNT_W      = 8;

endpackage

// File: rtl/trng_rct.sv
// Repetition-count health test: counts runs of identical raw bits and
// pulses trip on the bit that brings the run up to the cutoff.
module trng_rct
    import trng_pkg::*;
#(
    parameter int RCT_CUTOFF = RCT_CUTOFF_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_bit,
    input  logic raw_vld,
    input  logic clear,
    output logic trip
);

    localparam logic [RCT_CNT_W-1:0] CUTOFF = RCT_CNT_W'(RCT_CUTOFF);

    logic [RCT_CNT_W-1:0] cnt_p0;
    logic [RCT_CNT_W-1:0] cnt_nxt;
    logic                 prev_p0;
    logic                 repeat_bit;

    function automatic logic [RCT_CNT_W-1:0] sat_inc(input logic [RCT_CNT_W-1:0] cnt);
        if (cnt >= CUTOFF) begin
            return CUTOFF;
        end
        return cnt + 1'b1;
    endfunction

    // A zero count means no bit seen since the last clear.
    always_comb begin
        repeat_bit = (cnt_p0 != '0) && (raw_bit == prev_p0);
        cnt_nxt    = repeat_bit ? sat_inc(cnt_p0) : RCT_CNT_W'(1);
        trip       = raw_vld && !clear && (cnt_nxt >= CUTOFF);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_p0 <= '0;
        end else if (raw_vld) begin
            cnt_p0 <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (raw_vld && !clear) begin
            prev_p0 <= raw_bit;
        end
    end

endmodule

// File: rtl/trng_postproc.sv
// Entropy post-processing: health test, optional von Neumann debias,
// LSB-first word packing and a one-word output register with valid/ready.
module trng_postproc
    import trng_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RCT_CUTOFF = RCT_CUTOFF_DEF
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              EN_I,
    input  logic              RAW_BIT_I,
    input  logic              RAW_VLD_I,
    input  logic              VN_BYPASS_I,
    output logic [DATA_W-1:0] DATA_O,
    output logic              DATA_VLD_O,
    input  logic              DATA_RDY_I,
    output logic              RCT_FAIL_O,
    input  logic              FAIL_CLR_I,
    output logic              DROP_O
);

    localparam int              CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    state_e state_p0;
    state_e state_nxt;
    logic   in_run;
    logic   in_off;

    logic              take;
    logic              rct_clear;
    logic              rct_trip;
    logic              flush;
    logic              emit;
    logic              emit_bit;
    logic              wr;
    logic              drop_evt;
    logic              done;
    logic              accept;
    logic              load_out;
    logic [DATA_W-1:0] word;

    logic              bypass_p0;
    logic              half_p0;
    logic              pair_p0;
    logic [CNT_W-1:0]  bit_cnt_p0;
    logic              full_p0;
    logic [DATA_W-1:0] pack_p0;
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;
    logic              fail_p1;
    logic              drop_p1;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_p0 <= ST_OFF;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        if (!EN_I) begin
            state_nxt = ST_OFF;
        end else begin
            case (state_p0)
                ST_OFF:  state_nxt = ST_RUN;
                ST_RUN:  if (rct_trip)   state_nxt = ST_FAIL;
                ST_FAIL: if (FAIL_CLR_I) state_nxt = ST_RUN;
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    always_comb begin
        in_run = (state_p0 == ST_RUN);
        in_off = (state_p0 == ST_OFF);
    end

    // A clear pulse wins over a raw bit arriving in the same cycle.
    always_comb begin
        take      = in_run && EN_I && RAW_VLD_I && !FAIL_CLR_I;
        rct_clear = !in_run || !EN_I || FAIL_CLR_I;
    end

    trng_rct #(
        .RCT_CUTOFF (RCT_CUTOFF)
    ) u_rct (
        .clk     (CLK_I),
        .rst     (RST_I),
        .raw_bit (RAW_BIT_I),
        .raw_vld (take),
        .clear   (rct_clear),
        .trip    (rct_trip)
    );

    // Stage 0: pair logic and packer
    always_comb begin
        flush    = !in_run || !EN_I || rct_trip;
        emit     = 1'b0;
        emit_bit = RAW_BIT_I;
        if (take) begin
            if (bypass_p0) begin
                emit = 1'b1;
            end else if (half_p0) begin
                emit     = (pair_p0 != RAW_BIT_I);
                emit_bit = pair_p0;
            end
        end
        wr       = emit && !full_p0;
        drop_evt = emit && full_p0;
        done     = wr && (bit_cnt_p0 == LAST);
        accept   = vld_p1 && DATA_RDY_I;
        load_out = done && (!vld_p1 || accept);
        word     = pack_p0;
        word[bit_cnt_p0] = emit_bit;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            bypass_p0  <= 1'b0;
            half_p0    <= 1'b0;
            bit_cnt_p0 <= '0;
            full_p0    <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            // Mode only changes while idle or between words.
            if (in_off || (done && !flush)) begin
                bypass_p0 <= VN_BYPASS_I;
            end
            if (flush) begin
                half_p0    <= 1'b0;
                bit_cnt_p0 <= '0;
                full_p0    <= 1'b0;
                vld_p1     <= 1'b0;
            end else begin
                if (take && !bypass_p0) begin
                    half_p0 <= !half_p0;
                end
                if (wr) begin
                    bit_cnt_p0 <= bit_cnt_p0 + 1'b1;
                end
                if (full_p0 && accept) begin
                    full_p0 <= 1'b0;
                end else if (done && !load_out) begin
                    full_p0 <= 1'b1;
                end
                if (done || (full_p0 && accept)) begin
                    vld_p1 <= 1'b1;
                end else if (accept) begin
                    vld_p1 <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (take && !bypass_p0 && !half_p0) begin
            pair_p0 <= RAW_BIT_I;
        end
        if (flush) begin
            pack_p0 <= '0;
        end else if (wr) begin
            pack_p0 <= word;
        end
    end

    // Stage 1: output register and sticky flags
    always_ff @(posedge CLK_I) begin
        if (RST_I || flush) begin
            data_p1 <= '0;
        end else if (full_p0 && accept) begin
            data_p1 <= pack_p0;
        end else if (load_out) begin
            data_p1 <= word;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            fail_p1 <= 1'b0;
            drop_p1 <= 1'b0;
        end else begin
            if (FAIL_CLR_I) begin
                fail_p1 <= 1'b0;
            end else if (rct_trip) begin
                fail_p1 <= 1'b1;
            end
            if (FAIL_CLR_I) begin
                drop_p1 <= 1'b0;
            end else if (drop_evt && !flush) begin
                drop_p1 <= 1'b1;
            end
        end
    end

    assign DATA_O     = data_p1;
    assign DATA_VLD_O = vld_p1;
    assign RCT_FAIL_O = fail_p1;
    assign DROP_O     = drop_p1;

endmodule

// File: tb/tb_trng_postproc.sv
// Directed bench for trng_postproc: packing, debias, health test,
// backpressure and reset/enable behaviour with hand-computed words.
module tb_trng_postproc;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        raw_bit;
    logic        raw_vld;
    logic        bypass;
    logic [31:0] data;
    logic        data_vld;
    logic        data_rdy;
    logic        rct_fail;
    logic        fail_clr;
    logic        drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trng_postproc #(
        .DATA_W     (32),
        .RCT_CUTOFF (32)
    ) dut (
        .CLK_I       (clk),
        .RST_I       (rst),
        .EN_I        (en),
        .RAW_BIT_I   (raw_bit),
        .RAW_VLD_I   (raw_vld),
        .VN_BYPASS_I (bypass),
        .DATA_O      (data),
        .DATA_VLD_O  (data_vld),
        .DATA_RDY_I  (data_rdy),
        .RCT_FAIL_O  (rct_fail),
        .FAIL_CLR_I  (fail_clr),
        .DROP_O      (drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    // Sends n bits of val, LSB first, on consecutive cycles.
    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            raw_bit = val[i];
            raw_vld = 1'b1;
            @(negedge clk);
        end
        raw_vld = 1'b0;
    endtask

    task automatic reenable();
        en = 1'b0;
        cycle();
        en = 1'b1;
        cycle();
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        raw_bit  = 1'b0;
        raw_vld  = 1'b0;
        bypass   = 1'b0;
        data_rdy = 1'b0;
        fail_clr = 1'b0;
        cycle();
        cycle();
        check("reset_data", data, 32'h0);
        check("reset_vld", {31'b0, data_vld}, 32'h0);
        check("reset_fail", {31'b0, rct_fail}, 32'h0);
        check("reset_drop", {31'b0, drop}, 32'h0);
        rst = 1'b0;

        // Bypass packing of alternating bits
        bypass   = 1'b1;
        data_rdy = 1'b1;
        en       = 1'b1;
        cycle();
        send_bits(32'h5555_5555, 32);
        check("bypass_vld", {31'b0, data_vld}, 32'h1);
        check("bypass_data", data, 32'h5555_5555);
        check("bypass_fail", {31'b0, rct_fail}, 32'h0);
        cycle();
        check("bypass_vld_drop", {31'b0, data_vld}, 32'h0);

        // Von Neumann: "10" pairs with interleaved "00"/"11" pairs
        bypass = 1'b0;
        reenable();
        for (int i = 0; i < 32; i++) begin
            send_bits(32'h1, 2);
            if (i < 11) send_bits((i % 2 == 0) ? 32'h0 : 32'h3, 2);
        end
        check("vn10_vld", {31'b0, data_vld}, 32'h1);
        check("vn10_data", data, 32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) send_bits(32'h2, 2);
        check("vn01_vld", {31'b0, data_vld}, 32'h1);
        check("vn01_data", data, 32'h0000_0000);
        cycle();
        check("vn01_vld_drop", {31'b0, data_vld}, 32'h0);

        // RCT: 31 ones then zero, word left pending, then 32 ones
        bypass   = 1'b1;
        data_rdy = 1'b0;
        reenable();
        send_bits(32'h7FFF_FFFF, 32);
        check("rct31_fail", {31'b0, rct_fail}, 32'h0);
        check("rct31_vld", {31'b0, data_vld}, 32'h1);
        check("rct31_data", data, 32'h7FFF_FFFF);
        send_bits(32'hFFFF_FFFF, 31);
        check("rct_pre_fail", {31'b0, rct_fail}, 32'h0);
        check("rct_pre_vld", {31'b0, data_vld}, 32'h1);
        check("rct_pre_data", data, 32'h7FFF_FFFF);
        send_bits(32'h1, 1);
        check("rct_trip_fail", {31'b0, rct_fail}, 32'h1);
        check("rct_trip_vld", {31'b0, data_vld}, 32'h0);
        send_bits(32'h0000_00A5, 8);
        check("fail_ignore_vld", {31'b0, data_vld}, 32'h0);
        check("fail_ignore_fail", {31'b0, rct_fail}, 32'h1);
        raw_bit  = 1'b1;
        raw_vld  = 1'b1;
        fail_clr = 1'b1;
        cycle();
        raw_vld  = 1'b0;
        fail_clr = 1'b0;
        check("clr_fail", {31'b0, rct_fail}, 32'h0);
        data_rdy = 1'b1;
        send_bits(32'hC3A5_96F0, 32);
        check("post_clr_vld", {31'b0, data_vld}, 32'h1);
        check("post_clr_data", data, 32'hC3A5_96F0);
        cycle();
        check("post_clr_vld_drop", {31'b0, data_vld}, 32'h0);

        // Backpressure: held word, packer-full word, dropped third word
        data_rdy = 1'b0;
        send_bits(32'h5555_5555, 32);
        check("bp_w1_vld", {31'b0, data_vld}, 32'h1);
        check("bp_w1_data", data, 32'h5555_5555);
        send_bits(32'hAAAA_AAAA, 32);
        check("bp_w2_stable", data, 32'h5555_5555);
        check("bp_w2_nodrop", {31'b0, drop}, 32'h0);
        send_bits(32'h5555_5555, 32);
        check("bp_drop", {31'b0, drop}, 32'h1);
        check("bp_w3_stable", data, 32'h5555_5555);
        check("bp_w3_vld", {31'b0, data_vld}, 32'h1);
        data_rdy = 1'b1;
        cycle();
        check("bp_next_vld", {31'b0, data_vld}, 32'h1);
        check("bp_next_data", data, 32'hAAAA_AAAA);
        cycle();
        check("bp_idle_vld", {31'b0, data_vld}, 32'h0);
        data_rdy = 1'b0;

        // Trip on a word-completing bit, then enable drop mid-word
        reenable();
        send_bits(32'hFFFF_FFFF, 32);
        check("trip_word_fail", {31'b0, rct_fail}, 32'h1);
        check("trip_word_vld", {31'b0, data_vld}, 32'h0);
        check("trip_word_drop", {31'b0, drop}, 32'h1);
        reenable();
        send_bits(32'h0001_5A5A, 17);
        en = 1'b0;
        cycle();
        check("en_off_vld", {31'b0, data_vld}, 32'h0);
        check("en_off_fail_kept", {31'b0, rct_fail}, 32'h1);
        check("en_off_drop_kept", {31'b0, drop}, 32'h1);
        en = 1'b1;
        cycle();
        data_rdy = 1'b1;
        send_bits(32'h0F1E_2D3C, 32);
        check("en_restart_vld", {31'b0, data_vld}, 32'h1);
        check("en_restart_data", data, 32'h0F1E_2D3C);
        cycle();

        // Reset mid-word
        send_bits(32'h0000_1234, 17);
        rst = 1'b1;
        cycle();
        check("rst_mid_data", data, 32'h0);
        check("rst_mid_vld", {31'b0, data_vld}, 32'h0);
        check("rst_mid_fail", {31'b0, rct_fail}, 32'h0);
        check("rst_mid_drop", {31'b0, drop}, 32'h0);
        rst = 1'b0;
        cycle();
        send_bits(32'h600D_F00D, 32);
        check("rst_restart_vld", {31'b0, data_vld}, 32'h1);
        check("rst_restart_data", data, 32'h600D_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trng_postproc.md
# trng_postproc

Entropy post-processing stage directly upstream of the TRNG register block. It takes the raw serial noise bit stream from the analog entropy source and runs a repetition-count health test on the raw bits. It optionally von-Neumann-debiases the bits, packs them LSB-first into 32-bit words, and presents each word over a valid/ready handshake to the register block, which buffers it for bus reads.

## Interface
- `DATA_W`, 32: output word width; must be a power of two, ≥8.
- `RCT_CUTOFF`, 32: run length of identical raw bits that trips the health test; legal range 2..255.
- `CLK_I` in 1: the single clock; all logic on the rising edge.
- `RST_I` in 1: reset, synchronous, active-high.
- `EN_I` in 1: stage enable; low forces state OFF.
- `RAW_BIT_I` in 1: raw noise bit.
- `RAW_VLD_I` in 1: `RAW_BIT_I` valid this cycle; there is no backpressure on the source.
- `VN_BYPASS_I` in 1: 1 passes raw bits to the packer without debiasing. Sample it only in OFF or at a word boundary.
- `DATA_O` out DATA_W: packed random word; reset value 0.
- `DATA_VLD_O` out 1: `DATA_O` holds a word; reset value 0.
- `DATA_RDY_I` in 1: consumer accepts the word this cycle.
- `RCT_FAIL_O` out 1: sticky health-test failure; reset value 0.
- `FAIL_CLR_I` in 1: single-cycle pulse that clears the failure.
- `DROP_O` out 1: sticky flag, set when a debiased bit is discarded for lack of space; reset value 0; cleared by `FAIL_CLR_I`.

## Operation
- **Top FSM states:** OFF, RUN, FAIL. Reset value is OFF.
- **OFF → RUN:** when `EN_I`=1.
- **Any state → OFF:** when `EN_I`=0. This clears the pair register, packer, RCT counter and output register. `DROP_O` and `RCT_FAIL_O` are kept.
- **RUN → FAIL:** when the RCT trips.
- **FAIL → RUN:** on `FAIL_CLR_I` (if `EN_I`=1).
- **Health test (RCT) in RUN:**
  - Operates on every raw bit with `RAW_VLD_I`=1, in both bypass and debias modes.
  - The counter loads 1 on the first bit after OFF/clear, and after any bit that differs from the previous one.
  - It increments on a repeated bit and saturates at `RCT_CUTOFF`.
  - Reaching `RCT_CUTOFF` sets `RCT_FAIL_O` and enters FAIL.
- **Entering FAIL:** flushes the packer, the pair register and the output register. `DATA_VLD_O` drops; this is the only permitted withdrawal of a valid word. Raw bits are ignored while in FAIL.
- **Von Neumann pair logic (bypass=0):** 1-bit pair register with a HALF flag.
  - The first bit of a pair is stored.
  - On the second bit: pair 10 emits 1, pair 01 emits 0, pairs 00/11 emit nothing. HALF then clears.
- **Bypass (bypass=1):** every raw bit is emitted.
- **Packer:** the emitted bit is written at position `bit_cnt`, then `bit_cnt` increments. The bit on which `bit_cnt` wraps from DATA_W-1 to 0 completes a word.
- **Word completion:**
  - If the output is empty, or `DATA_VLD_O`&&`DATA_RDY_I` this cycle, the word loads into the output register.
  - Otherwise the word is held in the packer (full flag set), and it moves to the output on the cycle the output is accepted.
  - While the packer is full, emitted bits are dropped and `DROP_O` is set.
- **Handshake:** `DATA_O` is stable while `DATA_VLD_O`=1 and `DATA_RDY_I`=0.
- **Simultaneous events:**
  - `FAIL_CLR_I` together with a raw bit: the clear wins and the bit is ignored.
  - RCT trip on the bit that completes a word: the flush wins and no word is emitted.

## Timing
- Raw bit sampled on edge t: RCT counter, pair register and packer update at edge t.
- `DATA_VLD_O` rises in the cycle after edge t when the completing bit sampled at t loads directly.
- A word accepted at edge t with a packer-full word pending: the next word is valid in the cycle after t, with no bubble.
- `RCT_FAIL_O` rises in the cycle after the edge that samples the `RCT_CUTOFF`-th identical bit.
- `RST_I` mid-word: all outputs return to reset values next cycle and the partial word is lost.

## Structure
- **Package `trng_pkg`:** holds the FSM state typedef (OFF/RUN/FAIL), the default `DATA_W` and `RCT_CUTOFF` constants, and the RCT counter width (8).
- **Sub-module `trng_rct`:** the repetition-count test. It takes bit/valid/clear inputs and produces a trip pulse. Pair logic, packer, FSM and output register stay in the top module.

## Test plan
- **Bypass packing:** EN=1, bypass=1, 32 bits alternating 1,0,1,0…, RDY=1 → `DATA_O`=0x55555555, `DATA_VLD_O` high one cycle, `RCT_FAIL_O`=0.
- **Von Neumann debias:** bypass=0, 32 pairs "10" with 11 interleaved "00"/"11" pairs → one word 0xFFFFFFFF. Then 32 pairs "01" → 0x00000000.
- **RCT trip:** cutoff 32, feed 31 ones then a zero → no fail. Feed 32 ones → `RCT_FAIL_O`=1 one cycle after the 32nd. Pending `DATA_VLD_O` drops. Subsequent bits are ignored until the `FAIL_CLR_I` pulse.
- **Backpressure:** RDY=0, bypass, 96 alternating bits → first word held stable in `DATA_O`, second word in packer, `DROP_O`=1. Raise RDY for 2 cycles → two words delivered back-to-back, then the valid/ready handshake goes idle.
- **Reset/enable mid-word:** 17 bits in, assert `RST_I` → all outputs 0. Repeat with `EN_I`=0 → the next word starts at bit 0 and `RCT_FAIL_O`/`DROP_O` are preserved.
